// File: rtl/text_pkg.sv
// Shared constants and host FSM encoding for the text RAM arbiter.
package text_pkg;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 30;
  localparam int TEXT_CELLS = TEXT_COLS * TEXT_ROWS;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    HOST_IDLE    = 2'd0,
    HOST_ISSUE   = 2'd1,
    HOST_CAPTURE = 2'd2,
    HOST_ACK     = 2'd3
  } host_state_e;

endpackage

// File: rtl/text_ram_arbiter.sv
// Shares one single-port text RAM between a fixed-latency display fetch and a req/ack host.
// Optional starvation monitor (host_starve output) enabled by `define TEXT_RAM_STARVE_MON_EN.
module text_ram_arbiter #(
  parameter int TEXT_COLS    = text_pkg::TEXT_COLS,
  parameter int TEXT_ROWS    = text_pkg::TEXT_ROWS,
  parameter int ADDR_W       = text_pkg::ADDR_W,
  parameter int DATA_W       = text_pkg::DATA_W,
  parameter int HOST_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef TEXT_RAM_STARVE_MON_EN
  ,
  output logic              host_starve
`endif
);

  import text_pkg::*;

  // One extra bit so a cell count equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] CELL_LIMIT = (ADDR_W + 1)'(TEXT_COLS * TEXT_ROWS);

  host_state_e       state_q;
  logic              op_we_q, op_err_q;
  logic              host_ack_q, host_err_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic              disp_p1_q, disp_p2_q, disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;

  logic host_grant;
  logic host_oor;

  assign host_oor   = {1'b0, host_addr} >= CELL_LIMIT;
  assign host_grant = host_req && !disp_req && (state_q == HOST_IDLE);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ram_en_d    = disp_req || (host_grant && !host_oor);
    ram_we_d    = host_grant && host_we && !host_oor;
    ram_addr_d  = disp_req ? disp_addr : host_addr;
    ram_wdata_d = '0;
    if (ram_we_d) ram_wdata_d = host_wdata;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      disp_p1_q    <= 1'b0;
      disp_p2_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      disp_p1_q    <= disp_req;
      disp_p2_q    <= disp_p1_q;
      disp_valid_q <= disp_p2_q;
      if (disp_p2_q) disp_data_q <= ram_rdata;
    end
  end

  // Host FSM: the port is used only on the cycle after the grant; the rest is response timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HOST_IDLE;
      op_we_q      <= 1'b0;
      op_err_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      host_ack_q <= 1'b0;
      host_err_q <= 1'b0;
      case (state_q)
        HOST_IDLE: begin
          if (host_grant) begin
            state_q  <= HOST_ISSUE;
            op_we_q  <= host_we;
            op_err_q <= host_oor;
          end
        end
        HOST_ISSUE: begin
          if (op_we_q || op_err_q) begin
            state_q    <= HOST_ACK;
            host_ack_q <= 1'b1;
            host_err_q <= op_err_q;
            if (!op_we_q) host_rdata_q <= '0;
          end else begin
            state_q <= HOST_CAPTURE;
          end
        end
        HOST_CAPTURE: begin
          state_q      <= HOST_ACK;
          host_ack_q   <= 1'b1;
          host_rdata_q <= ram_rdata;
        end
        HOST_ACK: state_q <= HOST_IDLE;
        default:  state_q <= HOST_IDLE;
      endcase
    end
  end

`ifdef TEXT_RAM_STARVE_MON_EN
  localparam int CNT_W = $clog2(HOST_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOST_TIMEOUT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             host_starve_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (host_grant) begin
      wait_cnt_d = '0;
    end else if (host_req && (state_q == HOST_IDLE) && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Sticky flag: only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      host_starve_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      host_starve_q <= host_starve_q || (wait_cnt_d == CNT_MAX);
    end
  end

  assign host_starve = host_starve_q;
`endif

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign host_ack   = host_ack_q;
  assign host_err   = host_err_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Scoreboard bench for text_ram_arbiter: drivers push expectations, a negedge monitor pops and compares.
module tb_text_ram_arbiter;
  import text_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req = 1'b0;
  logic [11:0] disp_addr = '0;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [11:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_err;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
`ifdef TEXT_RAM_STARVE_MON_EN
  logic        host_starve;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct { logic [7:0] data; int cyc; } disp_exp_t;
  typedef struct { logic [11:0] addr; int cyc; } port_exp_t;
  typedef struct { logic we; logic [7:0] rdata; logic err; int cyc; } host_exp_t;

  disp_exp_t disp_q[$];
  port_exp_t port_q[$];
  host_exp_t host_q[$];

  logic [7:0] mem     [4096];
  logic [7:0] ref_mem [4096];
  logic [7:0] last_rd = '0;

  text_ram_arbiter #(.HOST_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef TEXT_RAM_STARVE_MON_EN
    , .host_starve(host_starve)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM: read data valid the cycle after the enable.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  disp_exp_t de;
  port_exp_t pe;
  host_exp_t he;
  always @(negedge clk) begin
    if (!rst) begin
      if (disp_valid) begin
        if (disp_q.size() == 0) check("disp_unexpected", disp_valid, 0);
        else begin
          de = disp_q.pop_front();
          check("disp_cycle", cyc, de.cyc);
          check("disp_data", disp_data, de.data);
        end
      end else if (disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
        de = disp_q.pop_front();
        check("disp_missing", disp_valid, 1);
      end
      if (port_q.size() > 0 && port_q[0].cyc <= cyc) begin
        pe = port_q.pop_front();
        check("port_disp_op", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, pe.addr});
      end
      if (host_ack) begin
        if (host_q.size() == 0) check("host_unexpected", host_ack, 0);
        else begin
          he = host_q.pop_front();
          check("host_err", host_err, he.err);
          check("host_rdata", host_rdata, he.rdata);
          if (he.cyc >= 0) check("host_ack_cycle", cyc, he.cyc);
        end
      end else if (host_err) begin
        check("host_err_without_ack", host_err, host_ack);
      end
      if (ram_en && ram_we) check("ram_write_in_range", ram_addr < 12'(TEXT_CELLS), 1);
    end
  end

  task automatic disp_cycle(input logic req, input logic [11:0] addr);
    @(posedge clk); #1;
    disp_req  = req;
    disp_addr = addr;
    if (req) begin
      disp_q.push_back('{data: ref_mem[addr], cyc: cyc + 3});
      port_q.push_back('{addr: addr, cyc: cyc + 1});
    end
  endtask

  function automatic logic [11:0] disp_rand_addr();
    // Display reads stay away from host-writable cells so the model order is unambiguous.
    if ($urandom_range(0, 15) == 0) return 12'hFFF;
    return 12'h400 + 12'($urandom_range(0, 12'h3FF));
  endfunction

  task automatic disp_burst(input int n, input logic [11:0] addr, input bit rand_addr);
    for (int i = 0; i < n; i++) disp_cycle(1'b1, rand_addr ? disp_rand_addr() : addr);
    disp_cycle(1'b0, '0);
  endtask

  // lat > 0: expected ack cycle relative to the request cycle; 0: latency not checked.
  task automatic host_txn(input logic we, input logic [11:0] addr, input logic [7:0] wd, input int lat);
    host_exp_t e;
    int n;
    bit done;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    e.we  = we;
    e.err = (addr >= 12'(TEXT_CELLS));
    e.cyc = (lat > 0) ? cyc + lat : -1;
    if (!we) last_rd = e.err ? 8'h00 : ref_mem[addr];
    else if (!e.err) ref_mem[addr] = wd;
    e.rdata = last_rd;
    host_q.push_back(e);
    n = 0; done = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (host_ack) done = 1;
      n++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL host_timeout: no ack for addr 0x%0h within 300 cycles", addr);
      void'(host_q.pop_back());
    end
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic bus_check(input string name, input int dly, input logic en, input logic we,
                           input logic [11:0] addr, input logic [7:0] wd);
    @(posedge clk); #1;
    repeat (dly + 1) @(negedge clk);
    check({name, "_en"}, ram_en, en);
    if (en) check({name, "_op"}, {ram_we, ram_addr, ram_wdata}, {we, addr, wd});
  endtask

  task automatic flush_model();
    disp_q.delete();
    port_q.delete();
    host_q.delete();
    last_rd = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     <= 8'(i * 7 + 3);
      ref_mem[i]  = 8'(i * 7 + 3);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {disp_valid, host_ack, host_err, ram_en, ram_we}, 0);
    check("reset_data", {disp_data, host_rdata, ram_addr, ram_wdata}, 0);
`ifdef TEXT_RAM_STARVE_MON_EN
    check("reset_starve", host_starve, 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Host write then read, quiet display.
    fork
      host_txn(1'b1, 12'h005, 8'h41, 2);
      bus_check("wr_port", 1, 1'b1, 1'b1, 12'h005, 8'h41);
    join
    fork
      host_txn(1'b0, 12'h005, 8'h00, 3);
      bus_check("rd_port", 1, 1'b1, 1'b0, 12'h005, 8'h00);
    join

    // Display and host request in the same cycle: display first, host next.
    host_txn(1'b1, 12'h00A, 8'h33, 2);
    fork
      disp_burst(1, 12'h00A, 0);
      host_txn(1'b1, 12'h00B, 8'h5C, 3);
      bus_check("sim_host_port", 2, 1'b1, 1'b1, 12'h00B, 8'h5C);
    join

    // Display saturation with a pending host read.
    fork
      disp_burst(20, '0, 1);
      host_txn(1'b0, 12'h005, 8'h00, 23);
    join
`ifdef TEXT_RAM_STARVE_MON_EN
    check("starve_set", host_starve, 1);
`endif

    // Out-of-range boundary: 2400 is the first illegal cell.
    fork
      host_txn(1'b1, 12'd2400, 8'hEE, 2);
      bus_check("oor_wr_port", 1, 1'b0, 1'b0, '0, '0);
    join
    host_txn(1'b0, 12'd2400, 8'h00, 2);
    host_txn(1'b1, 12'd2399, 8'h7E, 2);
    host_txn(1'b0, 12'd2399, 8'h00, 3);

    // Asynchronous reset between edges while a display fetch is on the port.
    disp_cycle(1'b1, 12'h400);
    disp_cycle(1'b0, '0);
    #2;
    check("pre_reset_ram_en", ram_en, 1);
    rst = 1'b1;
    #1;
    check("async_reset_ctrl", {disp_valid, host_ack, host_err, ram_en, ram_we}, 0);
    check("async_reset_data", {disp_data, host_rdata, ram_addr, ram_wdata}, 0);
    flush_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_quiet", {disp_valid, host_ack}, 0);
    end

    // Reset in the cycle after a host read grant: the read is lost.
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h005;
    @(posedge clk); #2;
    rst = 1'b1;
    host_req = 1'b0;
    flush_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("aborted_read_no_ack", host_ack, 0);
    end
    host_txn(1'b0, 12'h005, 8'h00, 3);

    // Randomized mixed traffic.
    fork
      begin
        for (int i = 0; i < 400; i++)
          disp_cycle(($urandom_range(0, 99) < 55), disp_rand_addr());
        disp_cycle(1'b0, '0);
      end
      begin
        for (int t = 0; t < 40; t++) begin
          int r;
          logic [11:0] a;
          repeat ($urandom_range(0, 4)) @(posedge clk);
          r = $urandom_range(0, 9);
          if (r < 7)       a = 12'($urandom_range(0, 31));
          else if (r == 7) a = 12'd2399;
          else if (r == 8) a = 12'd2400;
          else             a = 12'($urandom_range(2400, 4095));
          host_txn(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), 0);
        end
      end
    join

    repeat (10) @(negedge clk);
    check("drain_disp", disp_q.size(), 0);
    check("drain_host", host_q.size(), 0);
`ifdef TEXT_RAM_STARVE_MON_EN
    check("starve_sticky", host_starve, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
